// File: rtl/bram_xfer_sequencer.sv
// Bank-range sequencer driving the BRAM write/read address counters, demux and mux.
// Define SEQ_ADDR_STRIDE_EN to offset each successive bank's start address by the word count.
module bram_xfer_sequencer #(
    parameter int WR_BANKS = 32,
    parameter int RD_BANKS = 16,
    parameter int ADDR_W   = 16,
    parameter int INSTR_W  = 8,
    parameter logic [INSTR_W-1:0] OP_WRITE = 'h01,
    parameter logic [INSTR_W-1:0] OP_READ  = 'h02,
    localparam int WR_SEL_W = $clog2(WR_BANKS),
    localparam int RD_SEL_W = $clog2(RD_BANKS)
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [INSTR_W-1:0]  instr_code,
    input  logic [WR_SEL_W-1:0] wr_bank_start,
    input  logic [WR_SEL_W-1:0] wr_bank_end,
    input  logic [ADDR_W-1:0]   wr_addr_start,
    input  logic [ADDR_W-1:0]   wr_addr_count,
    input  logic [RD_SEL_W-1:0] rd_bank_start,
    input  logic [RD_SEL_W-1:0] rd_bank_end,
    input  logic [ADDR_W-1:0]   rd_addr_start,
    input  logic [ADDR_W-1:0]   rd_addr_count,
    input  logic                abort,
    input  logic                bram_wr_enable,
    input  logic                wr_counter_done,
    input  logic                rd_counter_done,
    output logic                wr_counter_start,
    output logic                wr_counter_enable,
    output logic [ADDR_W-1:0]   wr_start_addr,
    output logic [ADDR_W-1:0]   wr_count_limit,
    output logic                rd_counter_start,
    output logic                rd_counter_enable,
    output logic [ADDR_W-1:0]   rd_start_addr,
    output logic [ADDR_W-1:0]   rd_count_limit,
    output logic [WR_SEL_W-1:0] demux_sel,
    output logic [RD_SEL_W-1:0] mux_sel,
    output logic                bram_rd_enable,
    output logic                busy,
    output logic                done,
    output logic                err
);

    typedef enum logic [2:0] {
        IDLE, WR_SETUP, WR_WAIT, RD_SETUP, RD_WAIT, DONE, ERR
    } state_t;

    state_t              state_q, state_d;
    logic [WR_SEL_W-1:0] wr_idx_q, wr_idx_d, wr_end_q, wr_end_d;
    logic [RD_SEL_W-1:0] rd_idx_q, rd_idx_d, rd_end_q, rd_end_d;
    logic [ADDR_W-1:0]   addr_q, addr_d, count_q, count_d;
    logic                wr_bad, rd_bad;

    assign wr_bad = (wr_bank_start > wr_bank_end) || (int'(wr_bank_end) >= WR_BANKS)
                    || (wr_addr_count == '0);
    assign rd_bad = (rd_bank_start > rd_bank_end) || (int'(rd_bank_end) >= RD_BANKS)
                    || (rd_addr_count == '0);

    // Only one direction runs at a time, so base and count share one latch pair.
    always_comb begin
        state_d  = state_q;
        wr_idx_d = wr_idx_q;
        wr_end_d = wr_end_q;
        rd_idx_d = rd_idx_q;
        rd_end_d = rd_end_q;
        addr_d   = addr_q;
        count_d  = count_q;
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    if (instr_code == OP_WRITE) begin
                        wr_idx_d = wr_bank_start;
                        wr_end_d = wr_bank_end;
                        addr_d   = wr_addr_start;
                        count_d  = wr_addr_count;
                        state_d  = wr_bad ? ERR : WR_SETUP;
                    end else if (instr_code == OP_READ) begin
                        rd_idx_d = rd_bank_start;
                        rd_end_d = rd_bank_end;
                        addr_d   = rd_addr_start;
                        count_d  = rd_addr_count;
                        state_d  = rd_bad ? ERR : RD_SETUP;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            WR_SETUP: state_d = WR_WAIT;
            WR_WAIT: begin
                if (wr_counter_done) begin
                    if (wr_idx_q < wr_end_q) begin
                        wr_idx_d = wr_idx_q + WR_SEL_W'(1);
`ifdef SEQ_ADDR_STRIDE_EN
                        addr_d   = addr_q + count_q;
`endif
                        state_d  = WR_SETUP;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RD_SETUP: state_d = RD_WAIT;
            RD_WAIT: begin
                if (rd_counter_done) begin
                    if (rd_idx_q < rd_end_q) begin
                        rd_idx_d = rd_idx_q + RD_SEL_W'(1);
`ifdef SEQ_ADDR_STRIDE_EN
                        addr_d   = addr_q + count_q;
`endif
                        state_d  = RD_SETUP;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort && (state_q != IDLE)) state_d = IDLE;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            wr_idx_q <= '0;
            wr_end_q <= '0;
            rd_idx_q <= '0;
            rd_end_q <= '0;
            addr_q   <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            wr_end_q <= wr_end_d;
            rd_idx_q <= rd_idx_d;
            rd_end_q <= rd_end_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
        end
    end

    assign instr_ready       = (state_q == IDLE);
    assign busy              = (state_q != IDLE);
    assign done              = (state_q == DONE);
    assign err               = (state_q == ERR);
    assign wr_counter_start  = (state_q == WR_SETUP);
    assign wr_start_addr     = (state_q == WR_SETUP) ? addr_q : '0;
    assign wr_count_limit    = (state_q == WR_SETUP) ? count_q : '0;
    assign wr_counter_enable = (state_q == WR_WAIT) && bram_wr_enable;
    assign demux_sel         = (state_q == WR_SETUP || state_q == WR_WAIT) ? wr_idx_q : '0;
    assign rd_counter_start  = (state_q == RD_SETUP);
    assign rd_start_addr     = (state_q == RD_SETUP) ? addr_q : '0;
    assign rd_count_limit    = (state_q == RD_SETUP) ? count_q : '0;
    assign rd_counter_enable = (state_q == RD_WAIT);
    assign bram_rd_enable    = (state_q == RD_WAIT);
    assign mux_sel           = (state_q == RD_SETUP || state_q == RD_WAIT) ? rd_idx_q : '0;

endmodule

// File: tb/tb_bram_xfer_sequencer.sv
// Directed self-checking bench for bram_xfer_sequencer; honours SEQ_ADDR_STRIDE_EN if defined.
module tb_bram_xfer_sequencer;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [7:0]  instr_code = '0;
    logic [4:0]  wr_bank_start = '0, wr_bank_end = '0;
    logic [15:0] wr_addr_start = '0, wr_addr_count = '0;
    logic [3:0]  rd_bank_start = '0, rd_bank_end = '0;
    logic [15:0] rd_addr_start = '0, rd_addr_count = '0;
    logic        abort = 1'b0, bram_wr_enable = 1'b0;
    logic        wr_counter_done = 1'b0, rd_counter_done = 1'b0;
    logic        wr_counter_start, wr_counter_enable, rd_counter_start, rd_counter_enable;
    logic [15:0] wr_start_addr, wr_count_limit, rd_start_addr, rd_count_limit;
    logic [4:0]  demux_sel;
    logic [3:0]  mux_sel;
    logic        bram_rd_enable, busy, done, err;

    int checks = 0;
    int failures = 0;
    int wrStarts = 0, rdStarts = 0, doneCount = 0, errCount = 0, acceptCount = 0;

    bram_xfer_sequencer dut (
        .aclk(aclk), .aresetn(aresetn),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_code(instr_code),
        .wr_bank_start(wr_bank_start), .wr_bank_end(wr_bank_end),
        .wr_addr_start(wr_addr_start), .wr_addr_count(wr_addr_count),
        .rd_bank_start(rd_bank_start), .rd_bank_end(rd_bank_end),
        .rd_addr_start(rd_addr_start), .rd_addr_count(rd_addr_count),
        .abort(abort), .bram_wr_enable(bram_wr_enable),
        .wr_counter_done(wr_counter_done), .rd_counter_done(rd_counter_done),
        .wr_counter_start(wr_counter_start), .wr_counter_enable(wr_counter_enable),
        .wr_start_addr(wr_start_addr), .wr_count_limit(wr_count_limit),
        .rd_counter_start(rd_counter_start), .rd_counter_enable(rd_counter_enable),
        .rd_start_addr(rd_start_addr), .rd_count_limit(rd_count_limit),
        .demux_sel(demux_sel), .mux_sel(mux_sel), .bram_rd_enable(bram_rd_enable),
        .busy(busy), .done(done), .err(err)
    );

    always #5 aclk = ~aclk;

    // Event tallies taken mid-cycle, where every input and output is settled.
    always @(negedge aclk) begin
        if (wr_counter_start) wrStarts++;
        if (rd_counter_start) rdStarts++;
        if (done) doneCount++;
        if (err) errCount++;
        if (instr_valid && instr_ready && aresetn) acceptCount++;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic issue_write(input logic [7:0] code, input logic [4:0] s, input logic [4:0] e,
                               input logic [15:0] base, input logic [15:0] cnt);
        instr_code = code; wr_bank_start = s; wr_bank_end = e;
        wr_addr_start = base; wr_addr_count = cnt; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic issue_read(input logic [3:0] s, input logic [3:0] e,
                              input logic [15:0] base, input logic [15:0] cnt);
        instr_code = 8'h02; rd_bank_start = s; rd_bank_end = e;
        rd_addr_start = base; rd_addr_count = cnt; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        tick(); tick();
        aresetn = 1'b1;
        #1;
        checks++;
        if (instr_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=1", instr_ready); end
        checks++;
        if ({busy, done, err, wr_counter_start, rd_counter_start, bram_rd_enable} !== 6'b0) begin
            failures++; $display("[TB] FAIL reset_status got=%b exp=0", {busy, done, err, wr_counter_start, rd_counter_start, bram_rd_enable});
        end
        checks++;
        if ({demux_sel, mux_sel, wr_start_addr, rd_count_limit} !== '0) begin
            failures++; $display("[TB] FAIL reset_data got=%h exp=0", {demux_sel, mux_sel, wr_start_addr, rd_count_limit});
        end
    endtask

    task automatic test_write_multi();
        int s0;
        logic [15:0] expAddr;
        s0 = wrStarts;
        issue_write(8'h01, 5'd3, 5'd5, 16'h0010, 16'd4);
        for (int b = 0; b < 3; b++) begin
`ifdef SEQ_ADDR_STRIDE_EN
            expAddr = 16'h0010 + 16'(4 * b);
`else
            expAddr = 16'h0010;
`endif
            checks++;
            if ({wr_counter_start, demux_sel} !== {1'b1, 5'(3 + b)}) begin
                failures++; $display("[TB] FAIL wr_setup bank%0d got start=%b sel=%0d exp start=1 sel=%0d", b, wr_counter_start, demux_sel, 3 + b);
            end
            checks++;
            if ({wr_start_addr, wr_count_limit} !== {expAddr, 16'd4}) begin
                failures++; $display("[TB] FAIL wr_load bank%0d got addr=%h lim=%0d exp addr=%h lim=4", b, wr_start_addr, wr_count_limit, expAddr);
            end
            tick();
            for (int w = 0; w < 4; w++) begin
                bram_wr_enable = 1'b1;
                #1;
                checks++;
                if ({wr_counter_enable, demux_sel, wr_counter_start} !== {1'b1, 5'(3 + b), 1'b0}) begin
                    failures++; $display("[TB] FAIL wr_wait bank%0d got en=%b sel=%0d start=%b exp en=1 sel=%0d start=0", b, wr_counter_enable, demux_sel, wr_counter_start, 3 + b);
                end
                tick();
                bram_wr_enable = 1'b0;
                #1;
                checks++;
                if (wr_counter_enable !== 1'b0) begin failures++; $display("[TB] FAIL wr_enable_idle got=%b exp=0", wr_counter_enable); end
            end
            wr_counter_done = 1'b1;
            tick();
            wr_counter_done = 1'b0;
        end
        checks++;
        if ({done, busy, instr_ready} !== 3'b110) begin
            failures++; $display("[TB] FAIL wr_done got done/busy/ready=%b exp=110", {done, busy, instr_ready});
        end
        tick();
        checks++;
        if ({done, busy, instr_ready} !== 3'b001) begin
            failures++; $display("[TB] FAIL wr_idle got done/busy/ready=%b exp=001", {done, busy, instr_ready});
        end
        checks++;
        if (wrStarts - s0 !== 3) begin failures++; $display("[TB] FAIL wr_start_count got=%0d exp=3", wrStarts - s0); end
    endtask

    task automatic test_read_single();
        issue_read(4'd15, 4'd15, 16'h0020, 16'd1);
        checks++;
        if ({rd_counter_start, mux_sel, rd_start_addr, rd_count_limit} !== {1'b1, 4'd15, 16'h0020, 16'd1}) begin
            failures++; $display("[TB] FAIL rd_setup got start=%b sel=%0d addr=%h lim=%0d exp 1/15/0020/1", rd_counter_start, mux_sel, rd_start_addr, rd_count_limit);
        end
        tick();
        for (int c = 0; c < 2; c++) begin
            checks++;
            if ({bram_rd_enable, rd_counter_enable, mux_sel, rd_counter_start} !== {1'b1, 1'b1, 4'd15, 1'b0}) begin
                failures++; $display("[TB] FAIL rd_wait cyc%0d got rden=%b en=%b sel=%0d start=%b", c, bram_rd_enable, rd_counter_enable, mux_sel, rd_counter_start);
            end
            if (c == 0) tick();
        end
        rd_counter_done = 1'b1;
        tick();
        rd_counter_done = 1'b0;
        checks++;
        if ({done, instr_ready, bram_rd_enable, mux_sel} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
            failures++; $display("[TB] FAIL rd_done got done=%b ready=%b rden=%b sel=%0d exp 1/0/0/0", done, instr_ready, bram_rd_enable, mux_sel);
        end
        tick();
        checks++;
        if ({done, instr_ready} !== 2'b01) begin failures++; $display("[TB] FAIL rd_ready got done/ready=%b exp=01", {done, instr_ready}); end
    endtask

    task automatic test_invalid();
        int s0, e0;
        s0 = wrStarts;
        for (int v = 0; v < 3; v++) begin
            e0 = errCount;
            case (v)
                0: issue_write(8'h01, 5'd7, 5'd2, 16'h0000, 16'd4);
                1: issue_write(8'h05, 5'd0, 5'd1, 16'h0000, 16'd4);
                default: issue_write(8'h01, 5'd0, 5'd0, 16'h0000, 16'd0);
            endcase
            checks++;
            if ({err, busy, wr_counter_start, done} !== 4'b1100) begin
                failures++; $display("[TB] FAIL invalid%0d got err/busy/start/done=%b exp=1100", v, {err, busy, wr_counter_start, done});
            end
            tick();
            checks++;
            if ({err, instr_ready} !== 2'b01) begin failures++; $display("[TB] FAIL invalid%0d_idle got err/ready=%b exp=01", v, {err, instr_ready}); end
            checks++;
            if (errCount - e0 !== 1) begin failures++; $display("[TB] FAIL invalid%0d_errpulses got=%0d exp=1", v, errCount - e0); end
        end
        checks++;
        if (wrStarts !== s0) begin failures++; $display("[TB] FAIL invalid_no_start got=%0d exp=0", wrStarts - s0); end
    endtask

    task automatic test_abort();
        int s0, d0, e0;
        s0 = wrStarts; d0 = doneCount; e0 = errCount;
        issue_write(8'h01, 5'd0, 5'd3, 16'h0100, 16'd2);
        for (int b = 0; b < 2; b++) begin
            tick();
            wr_counter_done = 1'b1;
            tick();
            wr_counter_done = 1'b0;
        end
        checks++;
        if ({wr_counter_start, demux_sel} !== {1'b1, 5'd2}) begin
            failures++; $display("[TB] FAIL abort_bank2 got start=%b sel=%0d exp 1/2", wr_counter_start, demux_sel);
        end
        tick();
        abort = 1'b1; wr_counter_done = 1'b1; bram_wr_enable = 1'b1;
        #1;
        checks++;
        if ({demux_sel, wr_counter_enable, busy} !== {5'd2, 1'b1, 1'b1}) begin
            failures++; $display("[TB] FAIL abort_cycle got sel=%0d en=%b busy=%b exp 2/1/1", demux_sel, wr_counter_enable, busy);
        end
        tick();
        abort = 1'b0; wr_counter_done = 1'b0; bram_wr_enable = 1'b0;
        checks++;
        if ({instr_ready, busy, done, err, wr_counter_start} !== 5'b10000) begin
            failures++; $display("[TB] FAIL abort_idle got ready/busy/done/err/start=%b exp=10000", {instr_ready, busy, done, err, wr_counter_start});
        end
        tick(); tick();
        checks++;
        if ({wrStarts - s0, doneCount - d0, errCount - e0} !== {32'd3, 32'd0, 32'd0}) begin
            failures++; $display("[TB] FAIL abort_tally got starts=%0d done=%0d err=%0d exp 3/0/0", wrStarts - s0, doneCount - d0, errCount - e0);
        end
    endtask

    task automatic test_back_to_back();
        int a0, r0;
        a0 = acceptCount; r0 = rdStarts;
        instr_code = 8'h02; rd_bank_start = 4'd0; rd_bank_end = 4'd1;
        rd_addr_start = 16'h0040; rd_addr_count = 16'd3; instr_valid = 1'b1;
        tick();
        tick();
        rd_counter_done = 1'b1;
        tick();
        rd_counter_done = 1'b0;
        checks++;
        if ({rd_counter_start, mux_sel} !== {1'b1, 4'd1}) begin
            failures++; $display("[TB] FAIL b2b_bank1 got start=%b sel=%0d exp 1/1", rd_counter_start, mux_sel);
        end
        tick();
        rd_counter_done = 1'b1;
        tick();
        rd_counter_done = 1'b0;
        checks++;
        if ({done, acceptCount - a0} !== {1'b1, 32'd1}) begin
            failures++; $display("[TB] FAIL b2b_single_accept got done=%b accepts=%0d exp 1/1", done, acceptCount - a0);
        end
        tick();
        checks++;
        if (instr_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_idle got ready=%b exp=1", instr_ready); end
        tick();
        instr_valid = 1'b0;
        checks++;
        if ({rd_counter_start, acceptCount - a0, rdStarts - r0} !== {1'b1, 32'd2, 32'd2}) begin
            failures++; $display("[TB] FAIL b2b_second got start=%b accepts=%0d starts=%0d exp 1/2/2", rd_counter_start, acceptCount - a0, rdStarts - r0);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_reset_mid();
        int d0, e0;
        issue_read(4'd2, 4'd4, 16'h0080, 16'd8);
        tick();
        checks++;
        if (bram_rd_enable !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_wait got rden=%b exp=1", bram_rd_enable); end
        d0 = doneCount; e0 = errCount;
        aresetn = 1'b0;
        tick();
        checks++;
        if ({instr_ready, busy, done, err, bram_rd_enable, rd_counter_enable, rd_counter_start, mux_sel} !== {1'b1, 10'b0}) begin
            failures++; $display("[TB] FAIL rstmid_outputs got=%b exp=10000000000", {instr_ready, busy, done, err, bram_rd_enable, rd_counter_enable, rd_counter_start, mux_sel});
        end
        aresetn = 1'b1;
        tick();
        checks++;
        if ({doneCount - d0, errCount - e0, instr_ready} !== {32'd0, 32'd0, 1'b1}) begin
            failures++; $display("[TB] FAIL rstmid_nopulse got done=%0d err=%0d ready=%b exp 0/0/1", doneCount - d0, errCount - e0, instr_ready);
        end
    endtask

    initial begin
        test_reset();
        test_write_multi();
        test_read_single();
        test_invalid();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
